// File: rtl/decoder_scan_sequencer.sv
// Row/strobe scan sequencer for a 3:8 decoder: steps rows 0..LAST_ROW, holding sel_en for DWELL
// cycles per row with BLANK low cycles between rows. All outputs are registered.
module decoder_scan_sequencer #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned BLANK    = 1,
  parameter int unsigned LAST_ROW = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       stop,
  output logic [0:2] sel,
  output logic       sel_en,
  output logic       row_tick,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDwell = 2'd1;
  localparam logic [1:0] StBlank = 2'd2;

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);
  localparam logic [7:0] BlankLast = (BLANK > 0) ? 8'(BLANK - 1) : 8'd0;
  localparam logic [2:0] LastRow   = 3'(LAST_ROW);
  localparam bit         HasBlank  = (BLANK > 0);

  logic [1:0] state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] row_next;
  logic       tick_d;

  assign row_next = (row_q == LastRow) ? 3'd0 : row_q + 3'd1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDwell;
          row_d   = 3'd0;
          cnt_d   = 8'd0;
        end
      end
      StDwell: begin
        if (cnt_q == DwellLast) begin
          cnt_d = 8'd0;
          if (row_q == LastRow && !continuous) begin
            state_d = StIdle;
            row_d   = 3'd0;
          end else if (HasBlank) begin
            // sel keeps the finished row through the blank gap
            state_d = StBlank;
          end else begin
            row_d = row_next;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d = StDwell;
          row_d   = row_next;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        row_d   = 3'd0;
        cnt_d   = 8'd0;
      end
    endcase
    // stop overrides everything, including a simultaneous start
    if (stop) begin
      state_d = StIdle;
      row_d   = 3'd0;
      cnt_d   = 8'd0;
    end
  end

  assign tick_d = (state_d == StDwell) && (cnt_d == DwellLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= 3'd0;
      cnt_q      <= 8'd0;
      sel        <= 3'd0;
      sel_en     <= 1'b0;
      row_tick   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      sel        <= row_d;
      sel_en     <= (state_d == StDwell);
      row_tick   <= tick_d;
      frame_done <= tick_d && (row_d == LastRow);
      busy       <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer: three parameterisations share one stimulus stream,
// expected outputs come from a time-since-start arithmetic model of the scan schedule.
module tb_decoder_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0;

  logic [0:2] sel0, sel1, sel2;
  logic en0, en1, en2, tick0, tick1, tick2, fd0, fd1, fd2, busy0, busy1, busy2;
  logic [6:0] act[3];

  assign act[0] = {sel0, en0, tick0, fd0, busy0};
  assign act[1] = {sel1, en1, tick1, fd1, busy1};
  assign act[2] = {sel2, en2, tick2, fd2, busy2};

  decoder_scan_sequencer #(.DWELL(4), .BLANK(1), .LAST_ROW(7)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .sel(sel0), .sel_en(en0), .row_tick(tick0), .frame_done(fd0), .busy(busy0)
  );
  decoder_scan_sequencer #(.DWELL(1), .BLANK(0), .LAST_ROW(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .sel(sel1), .sel_en(en1), .row_tick(tick1), .frame_done(fd1), .busy(busy1)
  );
  decoder_scan_sequencer #(.DWELL(3), .BLANK(2), .LAST_ROW(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
    .sel(sel2), .sel_en(en2), .row_tick(tick2), .frame_done(fd2), .busy(busy2)
  );

  int dw_c[3] = '{4, 1, 3};
  int bl_c[3] = '{1, 0, 2};
  int lr_c[3] = '{7, 3, 0};

  // Model state: whether a scan is active and cycles elapsed since its first dwell cycle
  bit m_act[3] = '{0, 0, 0};
  int m_t[3]   = '{0, 0, 0};

  logic [20:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // Output vector {sel, sel_en, row_tick, frame_done, busy} at time t into an active scan
  function automatic logic [6:0] outs(input bit a, input int t, input int dw, input int bl,
                                      input int lr);
    logic [6:0] o;
    int p, pos, row;
    o = 7'd0;
    if (a) begin
      p    = dw + bl;
      pos  = t % p;
      row  = (t / p) % (lr + 1);
      o[6:4] = 3'(row);
      o[3] = (pos < dw);
      o[2] = (pos == dw - 1);
      o[1] = o[2] && (row == lr);
      o[0] = 1'b1;
    end
    return o;
  endfunction

  task automatic cycle(input logic r, input logic s, input logic p, input logic c);
    logic [20:0] e;
    logic [6:0]  cur;
    @(negedge clk);
    rst = r;
    start = s;
    stop = p;
    continuous = c;
    for (int i = 0; i < 3; i++) begin
      cur = outs(m_act[i], m_t[i], dw_c[i], bl_c[i], lr_c[i]);
      if (r) begin
        m_act[i] = 1'b0;
      end else if (m_act[i]) begin
        if (p || (cur[1] && !c)) m_act[i] = 1'b0;
        else m_t[i] = m_t[i] + 1;
      end else if (s && !p) begin
        m_act[i] = 1'b1;
        m_t[i] = 0;
      end
      e[i*7 +: 7] = outs(m_act[i], m_t[i], dw_c[i], bl_c[i], lr_c[i]);
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    logic [20:0] e;
    logic [6:0]  x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          x = e[i*7 +: 7];
          checks++;
          if (act[i] !== x) begin
            errors++;
            $display("FAIL dut%0d outputs at %0t: got sel=%0d en=%b tick=%b fd=%b busy=%b, expected sel=%0d en=%b tick=%b fd=%b busy=%b",
                     i, $time, act[i][6:4], act[i][3], act[i][2], act[i][1], act[i][0],
                     x[6:4], x[3], x[2], x[1], x[0]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic c;
    c = 1'b0;
    repeat (4) cycle(1, 0, 0, 0);
    // single frame
    cycle(0, 1, 0, 0);
    repeat (45) cycle(0, 0, 0, 0);
    // continuous scan, then stop
    cycle(0, 1, 0, 1);
    repeat (90) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    // stop during row 2 dwell, then restart
    cycle(0, 1, 0, 0);
    repeat (11) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 0, 0);
    repeat (45) cycle(0, 0, 0, 0);
    // start held across whole frames
    repeat (100) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    // reset during the first blank, then start+stop together
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (3) cycle(0, 0, 0, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) c = ~c;
      cycle(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 3) == 0),
            logic'($urandom_range(0, 59) == 0), c);
    end
    repeat (2) cycle(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
